// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared encodings for the memory-access pipeline stage: operation
//            codes, access lengths, exception codes and FSM states, plus a
//            helper that gives the alignment mask for an access length.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOADS = 2'b10,
    OP_LOADU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    LEN_B = 2'b00,
    LEN_H = 2'b01,
    LEN_W = 2'b10,
    LEN_D = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    EXC_OK      = 2'b00,
    EXC_MISAL   = 2'b01,
    EXC_TIMEOUT = 2'b10,
    EXC_ILLEN   = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_OUT  = 2'b10
  } state_e;

  // Low address bits that must be zero for an access of 2^len bytes.
  function automatic logic [2:0] len_mask(input logic [1:0] len);
    case (len)
      LEN_B:   len_mask = 3'b000;
      LEN_H:   len_mask = 3'b001;
      LEN_W:   len_mask = 3'b011;
      default: len_mask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational byte-lane alignment between the pipeline and the
//            DATA_W-wide cache port.
//   off_i   in  byte offset inside the memory word
//   len_i   in  access length (byte/half/word/dword)
//   din_i   in  store data, right-justified
//   sext_i  in  1 = sign-extend load result
//   rdata_i in  aligned memory read word
//   wdata_o out store data replicated across all lanes
//   wstrb_o out byte strobes for the addressed lanes
//   rdata_o out load data extracted at the offset and extended
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W),
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        len_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              sext_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [15:0]       w_base;
  logic [DATA_W-1:0] w_shift;
  logic [IDX_W-1:0]  w_msb;
  logic              w_sign;

  // Replicating the datum into every lane means the strobes alone select
  // the destination bytes, so no variable shifter is needed on the store path.
  always_comb begin
    wdata_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (len_i)
        LEN_B:   wdata_o[i] = din_i[i % 8];
        LEN_H:   wdata_o[i] = din_i[i % 16];
        LEN_W:   wdata_o[i] = din_i[i % 32];
        default: wdata_o[i] = din_i[i % DATA_W];
      endcase
    end
  end

  always_comb begin
    w_base  = (16'd1 << (5'd1 << len_i)) - 16'd1;
    wstrb_o = STRB_W'(w_base << off_i);
  end

  // Load path: bring the addressed lane down to bit 0, then extend above the
  // lane's top bit with either its sign or zero.
  always_comb begin
    w_shift = rdata_i >> {off_i, 3'b000};
    case (len_i)
      LEN_B:   w_msb = IDX_W'(7);
      LEN_H:   w_msb = IDX_W'(15);
      LEN_W:   w_msb = IDX_W'(31);
      default: w_msb = IDX_W'(DATA_W - 1);
    endcase
    w_sign  = sext_i & w_shift[w_msb];
    rdata_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rdata_o[i] = (i <= int'(w_msb)) ? w_shift[i] : w_sign;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_stage
// Purpose  : Memory-access pipeline stage between EX and WB. Accepts one EX
//            result per handshake, issues loads/stores to the cache port with
//            lane alignment and misalignment/length/timeout trapping, and
//            presents results to WB with forwarding info back to decode.
//   clk, rst                 clock / async active-low reset
//   in_*                     EX-side valid/ready request
//   mem_*                    cache-side request/ack port
//   out_*                    WB-side valid/ready result
//   fwd_idx, fwd_val         forwardable result (idx 0 = none)
//   ld_pend_idx              destination of an in-flight load (0 = none)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int REG_IDX_W = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [1:0]            in_len,
  input  logic [ADDR_W-1:0]     in_ans,
  input  logic [DATA_W-1:0]     in_din,
  input  logic                  in_wb_e,
  input  logic [REG_IDX_W-1:0]  in_wb_idx,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wb_e,
  output logic [REG_IDX_W-1:0]  out_wb_idx,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_exc,
  output logic [REG_IDX_W-1:0]  fwd_idx,
  output logic [DATA_W-1:0]     fwd_val,
  output logic [REG_IDX_W-1:0]  ld_pend_idx
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [1:0]             len_q, len_d;
  logic [ADDR_W-1:0]      ans_q, ans_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic                   wb_e_q, wb_e_d;
  logic [REG_IDX_W-1:0]   wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0]      data_q, data_d;
  exc_e                   exc_q, exc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // Holds in_ready low while reset is asserted and for the first edge after.
  logic                   alive_q;

  logic                   accept;
  logic                   in_len_bad;
  logic                   in_misal;
  logic [DATA_W-1:0]      lane_wdata;
  logic [STRB_W-1:0]      lane_wstrb;
  logic [DATA_W-1:0]      lane_rdata;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .off_i   (ans_q[OFF_W-1:0]),
    .len_i   (len_q),
    .din_i   (din_q),
    .sext_i  (op_q == OP_LOADS),
    .rdata_i (mem_rdata),
    .wdata_o (lane_wdata),
    .wstrb_o (lane_wstrb),
    .rdata_o (lane_rdata)
  );

  assign in_ready   = alive_q & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
  assign accept     = in_valid & in_ready;
  assign in_len_bad = (DATA_W == 32) && (in_len == LEN_D);
  assign in_misal   = |(in_ans[2:0] & len_mask(in_len));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    ans_d    = ans_q;
    din_d    = din_q;
    wb_e_d   = wb_e_q;
    wb_idx_d = wb_idx_q;
    data_d   = data_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_MEM: begin
        // An ack in the timeout cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = ST_OUT;
          exc_d   = EXC_OK;
          if (op_q == OP_STORE) begin
            wb_e_d = 1'b0;
            data_d = '0;
          end else begin
            data_d = lane_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = ST_OUT;
          exc_d   = EXC_TIMEOUT;
          wb_e_d  = 1'b0;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A new op may arrive from IDLE or while OUT is being drained.
    if (accept) begin
      op_d     = op_e'(in_op);
      len_d    = in_len;
      ans_d    = in_ans;
      din_d    = in_din;
      wb_idx_d = in_wb_idx;
      wb_e_d   = in_wb_e;
      exc_d    = EXC_OK;
      data_d   = '0;
      cnt_d    = '0;
      if (op_e'(in_op) == OP_NONE) begin
        state_d = ST_OUT;
        data_d  = DATA_W'(in_ans);
      end else if (in_len_bad) begin
        state_d = ST_OUT;
        exc_d   = EXC_ILLEN;
        wb_e_d  = 1'b0;
      end else if (in_misal) begin
        state_d = ST_OUT;
        exc_d   = EXC_MISAL;
        wb_e_d  = 1'b0;
      end else begin
        state_d = ST_MEM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      len_q    <= '0;
      ans_q    <= '0;
      din_q    <= '0;
      wb_e_q   <= 1'b0;
      wb_idx_q <= '0;
      data_q   <= '0;
      exc_q    <= EXC_OK;
      cnt_q    <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      ans_q    <= ans_d;
      din_q    <= din_d;
      wb_e_q   <= wb_e_d;
      wb_idx_q <= wb_idx_d;
      data_q   <= data_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
      alive_q  <= 1'b1;
    end
  end

  // Every output is qualified by the state register so the async reset
  // clears them all immediately.
  assign mem_req     = (state_q == ST_MEM);
  assign mem_we      = mem_req & (op_q == OP_STORE);
  assign mem_addr    = mem_req ? {ans_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata   = mem_we ? lane_wdata : '0;
  assign mem_wstrb   = mem_we ? lane_wstrb : '0;

  assign out_valid   = (state_q == ST_OUT);
  assign out_wb_e    = out_valid & wb_e_q;
  assign out_wb_idx  = out_valid ? wb_idx_q : '0;
  assign out_data    = out_valid ? data_q : '0;
  assign out_exc     = out_valid ? exc_q : EXC_OK;

  // A zero wb_idx naturally yields "no forward".
  assign fwd_idx     = (out_valid && wb_e_q && (exc_q == EXC_OK)) ? wb_idx_q : '0;
  assign fwd_val     = out_data;
  assign ld_pend_idx = (mem_req && op_q[1] && wb_e_q) ? wb_idx_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_mem_stage
// Purpose  : Directed scoreboard bench for pipe_mem_stage (DATA_W=64,
//            TIMEOUT=4). Stimulus pushes expected WB results; a monitor pops
//            and compares on every WB handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_stage;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [1:0]    in_len;
  logic [AW-1:0] in_ans;
  logic [DW-1:0] in_din;
  logic          in_wb_e;
  logic [RW-1:0] in_wb_idx;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          out_valid;
  logic          out_ready;
  logic          out_wb_e;
  logic [RW-1:0] out_wb_idx;
  logic [DW-1:0] out_data;
  logic [1:0]    out_exc;
  logic [RW-1:0] fwd_idx;
  logic [DW-1:0] fwd_val;
  logic [RW-1:0] ld_pend_idx;

  pipe_mem_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_IDX_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_len(in_len),
    .in_ans(in_ans), .in_din(in_din), .in_wb_e(in_wb_e), .in_wb_idx(in_wb_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_e(out_wb_e),
    .out_wb_idx(out_wb_idx), .out_data(out_data), .out_exc(out_exc),
    .fwd_idx(fwd_idx), .fwd_val(fwd_val), .ld_pend_idx(ld_pend_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        chk_data;
    logic        wbe;
    logic [1:0]  exc;
    logic [4:0]  idx;
    logic [4:0]  fwd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic c, input logic w,
                      input logic [1:0] e, input logic [4:0] i, input logic [4:0] f);
    exp_t x;
    x.data = d; x.chk_data = c; x.wbe = w; x.exc = e; x.idx = i; x.fwd = f;
    sb.push_back(x);
  endtask

  // Drives one op and returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] len, input logic [63:0] ans,
                       input logic [63:0] din, input logic wbe, input logic [4:0] idx);
    int k;
    in_valid = 1'b1; in_op = op; in_len = len; in_ans = ans;
    in_din = din; in_wb_e = wbe; in_wb_idx = idx;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic ack(input logic [63:0] rd);
    mem_rdata = rd; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  // Monitor: compare every WB handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_data) check("out_data", out_data, mon_e.data);
        check("out_wb_e", 64'(out_wb_e), 64'(mon_e.wbe));
        check("out_exc", 64'(out_exc), 64'(mon_e.exc));
        check("out_wb_idx", 64'(out_wb_idx), 64'(mon_e.idx));
        check("fwd_idx", 64'(fwd_idx), 64'(mon_e.fwd));
        if (mon_e.chk_data) check("fwd_val", fwd_val, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_len = '0; in_ans = '0; in_din = '0;
    in_wb_e = 1'b0; in_wb_idx = '0; mem_rdata = '0; mem_ack = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_fwd_idx", 64'(fwd_idx), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Signed byte load at 0x1003
    push(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1, 2'b00, 5'd5, 5'd5);
    issue(2'b10, 2'b00, 64'h1003, 64'h0, 1'b1, 5'd5);
    check("lds_mem_req", 64'(mem_req), 64'd1);
    check("lds_mem_addr", mem_addr, 64'h1000);
    check("lds_mem_we", 64'(mem_we), 64'd0);
    check("lds_wstrb", 64'(mem_wstrb), 64'd0);
    check("lds_ld_pend", 64'(ld_pend_idx), 64'd5);
    ack(64'h0000_0000_80FF_0000);
    check("lds_req_drop", 64'(mem_req), 64'd0);
    @(posedge clk); #1;

    // Unsigned byte load at 0x1003, WB stalls one extra cycle
    push(64'h80, 1'b1, 1'b1, 2'b00, 5'd8, 5'd8);
    issue(2'b11, 2'b00, 64'h1003, 64'h0, 1'b1, 5'd8);
    out_ready = 1'b0;
    ack(64'h0000_0000_80FF_0000);
    @(posedge clk); #1;
    check("ldu_hold_valid", 64'(out_valid), 64'd1);
    check("ldu_hold_data", out_data, 64'h80);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Half store 0xBEEF at 0x2006
    push(64'h0, 1'b0, 1'b0, 2'b00, 5'd9, 5'd0);
    issue(2'b01, 2'b01, 64'h2006, 64'hBEEF, 1'b1, 5'd9);
    check("st_mem_we", 64'(mem_we), 64'd1);
    check("st_mem_addr", mem_addr, 64'h2000);
    check("st_wstrb", 64'(mem_wstrb), 64'hC0);
    check("st_wdata_hi", 64'(mem_wdata[63:48]), 64'hBEEF);
    check("st_ld_pend", 64'(ld_pend_idx), 64'd0);
    ack(64'h0);
    @(posedge clk); #1;

    // Misaligned word load at 0x3002: no memory access
    push(64'h0, 1'b0, 1'b0, 2'b01, 5'd4, 5'd0);
    issue(2'b10, 2'b10, 64'h3002, 64'h0, 1'b1, 5'd4);
    check("mis_mem_req", 64'(mem_req), 64'd0);
    check("mis_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Three back-to-back pass-through ops
    push(64'h11, 1'b1, 1'b1, 2'b00, 5'd1, 5'd1);
    push(64'hFFFF_0000_1234_5678, 1'b1, 1'b1, 2'b00, 5'd2, 5'd2);
    push(64'h33, 1'b1, 1'b1, 2'b00, 5'd3, 5'd3);
    issue(2'b00, 2'b00, 64'h11, 64'h0, 1'b1, 5'd1);
    check("b2b0_valid", 64'(out_valid), 64'd1);
    check("b2b0_ready", 64'(in_ready), 64'd1);
    issue(2'b00, 2'b00, 64'hFFFF_0000_1234_5678, 64'h0, 1'b1, 5'd2);
    check("b2b1_valid", 64'(out_valid), 64'd1);
    check("b2b1_ready", 64'(in_ready), 64'd1);
    issue(2'b00, 2'b00, 64'h33, 64'h0, 1'b1, 5'd3);
    check("b2b2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Timeout: no ack ever
    push(64'h0, 1'b0, 1'b0, 2'b10, 5'd6, 5'd0);
    issue(2'b11, 2'b11, 64'h4000, 64'h0, 1'b1, 5'd6);
    check("to_ld_pend", 64'(ld_pend_idx), 64'd6);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_req_cycles", 64'(n), 64'd4);
    @(posedge clk); #1;

    // Ack in the 4th MEM cycle beats the timeout
    push(64'h1122_3344_5566_7788, 1'b1, 1'b1, 2'b00, 5'd6, 5'd6);
    issue(2'b11, 2'b11, 64'h4000, 64'h0, 1'b1, 5'd6);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("to_ack_req", 64'(mem_req), 64'd1);
    ack(64'h1122_3344_5566_7788);
    @(posedge clk); #1;

    // Reset while a load to r7 is in flight
    issue(2'b10, 2'b00, 64'h5000, 64'h0, 1'b1, 5'd7);
    check("rst_pend_before", 64'(ld_pend_idx), 64'd7);
    #2 rst = 1'b0;
    #1;
    check("rst_pend_after", 64'(ld_pend_idx), 64'd0);
    check("rst_mid_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_mem_addr", mem_addr, 64'h0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    #4 rst = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ack = (c == 2);
      @(posedge clk); #1;
      if (out_valid || mem_req) n++;
    end
    mem_ack = 1'b0;
    check("post_rst_no_activity", 64'(n), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
